branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Parametrised branch-resolution stage for the MIPS32 pipeline. Evaluates the branch condition
//  (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ/BLTZAL/BGEZAL), computes the target, and compares both against
//  the fetch-stage prediction. On a mispredict it holds a redirect request until fetch accepts it.
//  Also counts resolved branches and mispredicts. Sits between decode operand-forwarding and fetch.
// PARAMETERS
//  DATA_W  32  operand width; sign bit is a[DATA_W-1]
//  PIPE    0   extra register stages on compare path (0 or 1); latency = 1+PIPE cycles
//  CNT_W   32  width of branch / mispredict counters (saturating)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       synchronous, active-high reset
//  flush          in   1       kill all in-flight entries (exception/eret), counters untouched
//  in_valid       in   1       branch-candidate instruction presented
//  in_ready       out  1       unit can accept (low while redirect pending)
//  op             in   6       instr[31:26]
//  rt             in   5       instr[20:16] (REGIMM sub-op)
//  a, b           in   DATA_W  forwarded rs, rt values
//  pc             in   32      PC of the branch instruction
//  imm            in   16      instr[15:0] offset
//  pred_taken     in   1       fetch prediction taken
//  pred_target    in   32      fetch predicted target (ignored if pred_taken=0)
//  out_valid      out  1       resolution result valid (1-cycle pulse per accepted branch)
//  out_taken      out  1       resolved condition
//  out_link       out  1       taken-or-not link write required (BLTZAL/BGEZAL), writes pc+8 to $31
//  redirect_valid out  1       mispredict redirect request
//  redirect_pc    out  32      corrected fetch PC
//  redirect_ready in   1       fetch accepts redirect
//  branch_cnt     out  CNT_W   resolved branches
//  mispred_cnt    out  CNT_W   mispredicted branches
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, pipeline valids cleared; in_ready=1 after reset.
//  Accept: in_valid & in_ready & is_branch. Non-branch op (incl. REGIMM with other rt) is dropped,
//   no out_valid, no count. Opcodes: BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111,
//   REGIMM 000001 with rt BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001.
//  Conditions: BEQ a==b; BNE a!=b; BGTZ !a[MSB]&a!=0; BLEZ a[MSB]|a==0; BLTZ* a[MSB]; BGEZ* !a[MSB].
//  Target = pc+4+{{14{imm[15]}},imm,2'b00}, 32-bit wraparound (no overflow flag).
//  Fall-through = pc+8 (delay slot already fetched). Correct = taken ? target : pc+8.
//  Mispredict when out_taken!=pred_taken, or both taken and pred_target!=target.
//  Latency: operands captured at accept edge; out_valid asserted 1+PIPE cycles later. PIPE=0 fully
//   pipelined, one branch/cycle; PIPE=1 two entries in flight max.
//  FSM: IDLE -> REDIRECT on out_valid&mispredict (same edge sets redirect_valid, redirect_pc).
//   REDIRECT: redirect_valid/pc held stable, in_ready=0; -> IDLE on redirect_ready (redirect_valid
//   drops next cycle). Younger entry already in flight when mispredict resolves is discarded.
//  Counters: branch_cnt +1 per out_valid; mispred_cnt +1 per mispredict; both saturate at all-ones.
//  flush: same-cycle in_valid ignored; in-flight entries cleared; REDIRECT -> IDLE, redirect_valid=0
//   next cycle; flush beats redirect_ready. rst overrides flush.
//  Reset mid-operation (any state) returns to reset values next edge.
// TESTING
//  BEQ a=b=0x5, pc=0x400, imm=0x0004, pred_taken=0 -> out_taken=1, redirect_pc=0x414, mispred_cnt=1.
//  BGTZ a=0x80000000, pred_taken=0 -> out_taken=0, no redirect, branch_cnt+1; a=0 also not taken.
//  BLTZAL a=0xFFFFFFFF, pred_taken=1, pred_target correct -> out_taken=1, out_link=1, no redirect.
//  BNE taken, pred_target wrong; hold redirect_ready=0 5 cycles -> redirect_valid/pc stable, in_ready=0.
//  imm=0x8000 at pc=0x0000_0010 -> target 0xFFFE_0014 (wrap); PIPE=1 -> out_valid 2 cycles after accept.
//  flush during REDIRECT -> redirect_valid=0 next cycle; rst mid-stream -> all outputs/counters 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// MIPS32 branch resolution: evaluates condition and target, checks the
// fetch prediction, holds a redirect until fetch takes it, counts outcomes.
module branch_resolve_unit #(
    parameter int DATA_W = 32,
    parameter int PIPE   = 0,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op,
    input  logic [4:0]        rt,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [31:0]       pc,
    input  logic [15:0]       imm,
    input  logic              pred_taken,
    input  logic [31:0]       pred_target,
    output logic              out_valid,
    output logic              out_taken,
    output logic              out_link,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    input  logic              redirect_ready,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);
    typedef enum logic {IDLE, REDIRECT} state_t;

    localparam logic [2:0] K_BEQ  = 3'd0;
    localparam logic [2:0] K_BNE  = 3'd1;
    localparam logic [2:0] K_BLEZ = 3'd2;
    localparam logic [2:0] K_BGTZ = 3'd3;
    localparam logic [2:0] K_BLTZ = 3'd4;
    localparam logic [2:0] K_BGEZ = 3'd5;

    typedef struct packed {
        logic [2:0]        kind;
        logic              link;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [31:0]       pc;
        logic [15:0]       imm;
        logic              pred_taken;
        logic [31:0]       pred_target;
    } ent_t;

    typedef struct packed {
        logic        taken;
        logic        link;
        logic        mispred;
        logic [31:0] pc;
    } res_t;

    state_t           state_q, state_d;
    ent_t             s0_q, s0_d;
    logic             s0_valid_q, s0_valid_d;
    logic [31:0]      rpc_q, rpc_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;

    logic        is_branch, is_link, accept;
    logic [2:0]  kind;
    logic        a_neg, a_zero, cond;
    logic [31:0] target, fall;
    res_t        res, f_res;
    logic        f_valid;

    always_comb begin
        is_branch = 1'b1;
        is_link   = 1'b0;
        kind      = K_BEQ;
        unique case (op)
            6'b000100: kind = K_BEQ;
            6'b000101: kind = K_BNE;
            6'b000110: kind = K_BLEZ;
            6'b000111: kind = K_BGTZ;
            6'b000001: begin
                unique case (rt)
                    5'b00000: kind = K_BLTZ;
                    5'b00001: kind = K_BGEZ;
                    5'b10000: begin kind = K_BLTZ; is_link = 1'b1; end
                    5'b10001: begin kind = K_BGEZ; is_link = 1'b1; end
                    default:  is_branch = 1'b0;
                endcase
            end
            default: is_branch = 1'b0;
        endcase
    end

    // A resolving mispredict closes the door so no younger branch slips in.
    assign out_valid = f_valid & ~flush;
    assign in_ready  = (state_q == IDLE) & ~(out_valid & f_res.mispred);
    assign accept    = in_valid & in_ready & is_branch & ~flush;

    always_comb begin
        s0_valid_d = accept;
        s0_d       = s0_q;
        if (accept) begin
            s0_d.kind        = kind;
            s0_d.link        = is_link;
            s0_d.a           = a;
            s0_d.b           = b;
            s0_d.pc          = pc;
            s0_d.imm         = imm;
            s0_d.pred_taken  = pred_taken;
            s0_d.pred_target = pred_target;
        end
    end

    always_comb begin
        a_neg  = s0_q.a[DATA_W-1];
        a_zero = (s0_q.a == '0);
        unique case (s0_q.kind)
            K_BEQ:   cond = (s0_q.a == s0_q.b);
            K_BNE:   cond = (s0_q.a != s0_q.b);
            K_BLEZ:  cond = a_neg | a_zero;
            K_BGTZ:  cond = ~a_neg & ~a_zero;
            K_BLTZ:  cond = a_neg;
            K_BGEZ:  cond = ~a_neg;
            default: cond = 1'b0;
        endcase
        target = s0_q.pc + 32'd4 +
                 {{14{s0_q.imm[15]}}, s0_q.imm, 2'b00};
        fall   = s0_q.pc + 32'd8;
        res.taken   = cond;
        res.link    = s0_q.link;
        res.mispred = (cond != s0_q.pred_taken) |
                      (cond & s0_q.pred_taken &
                       (s0_q.pred_target != target));
        res.pc      = cond ? target : fall;
    end

    if (PIPE == 1) begin : g_pipe
        logic s1_valid_q, s1_valid_d;
        res_t s1_q, s1_d;

        always_comb begin
            s1_valid_d = s0_valid_q & ~flush &
                         ~(out_valid & f_res.mispred);
            s1_d       = res;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid_q <= 1'b0;
                s1_q       <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_q       <= s1_d;
            end
        end

        assign f_valid = s1_valid_q;
        assign f_res   = s1_q;
    end else begin : g_nopipe
        assign f_valid = s0_valid_q;
        assign f_res   = res;
    end

    always_comb begin
        state_d = state_q;
        rpc_d   = rpc_q;
        unique case (state_q)
            IDLE: begin
                if (out_valid & f_res.mispred) begin
                    state_d = REDIRECT;
                    rpc_d   = f_res.pc;
                end
            end
            REDIRECT: begin
                if (flush | redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        if (out_valid && !(&bcnt_q)) bcnt_d = bcnt_q + CNT_W'(1);
        if (out_valid && f_res.mispred && !(&mcnt_q))
            mcnt_d = mcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s0_valid_q <= 1'b0;
            s0_q       <= '0;
            rpc_q      <= '0;
            bcnt_q     <= '0;
            mcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            s0_valid_q <= s0_valid_d;
            s0_q       <= s0_d;
            rpc_q      <= rpc_d;
            bcnt_q     <= bcnt_d;
            mcnt_q     <= mcnt_d;
        end
    end

    assign out_taken      = out_valid & f_res.taken;
    assign out_link       = out_valid & f_res.link;
    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = rpc_q;
    assign branch_cnt     = bcnt_q;
    assign mispred_cnt    = mcnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: a PIPE=0/CNT_W=32 and a PIPE=1/CNT_W=4
// instance share stimulus and are checked against a reference model.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, redirect_ready;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] a, b, pc, pred_target;
    logic [15:0] imm;
    logic        pred_taken;

    logic        ir [2];
    logic        ov [2];
    logic        ot [2];
    logic        ol [2];
    logic        rv [2];
    logic [31:0] rpc [2];
    logic [31:0] bc0, mc0;
    logic [3:0]  bc1, mc1;

    int errors = 0;
    int checks = 0;
    int exp_b  = 0;
    int exp_m  = 0;
    logic [31:0] last_rpc [2];

    typedef struct {
        bit          is_br;
        bit          taken;
        bit          link;
        logic [31:0] target;
        bit          mis;
        logic [31:0] corr;
    } mres_t;

    typedef struct {
        int due;
        bit taken;
        bit link;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];

    always #5 clk = ~clk;

    branch_resolve_unit #(.DATA_W(32), .PIPE(0), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]),
        .op(op), .rt(rt), .a(a), .b(b), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .out_valid(ov[0]), .out_taken(ot[0]), .out_link(ol[0]),
        .redirect_valid(rv[0]), .redirect_pc(rpc[0]),
        .redirect_ready(redirect_ready),
        .branch_cnt(bc0), .mispred_cnt(mc0)
    );

    branch_resolve_unit #(.DATA_W(32), .PIPE(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]),
        .op(op), .rt(rt), .a(a), .b(b), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .out_valid(ov[1]), .out_taken(ot[1]), .out_link(ol[1]),
        .redirect_valid(rv[1]), .redirect_pc(rpc[1]),
        .redirect_ready(redirect_ready),
        .branch_cnt(bc1), .mispred_cnt(mc1)
    );

    function automatic mres_t model(input logic [5:0] o,
                                    input logic [4:0] r,
                                    input logic [31:0] av, bv, pcv,
                                    input logic [15:0] iv,
                                    input bit ptv,
                                    input logic [31:0] ptg);
        mres_t m;
        int sa, off;
        sa = $signed(av);
        off = $signed(iv);
        m.is_br = 1;
        m.link  = 0;
        m.taken = 0;
        case (o)
            6'd4: m.taken = (av == bv);
            6'd5: m.taken = (av != bv);
            6'd6: m.taken = (sa <= 0);
            6'd7: m.taken = (sa > 0);
            6'd1: begin
                if (r == 5'd0 || r == 5'd16) m.taken = (sa < 0);
                else if (r == 5'd1 || r == 5'd17) m.taken = (sa >= 0);
                else m.is_br = 0;
                m.link = (r == 5'd16 || r == 5'd17);
            end
            default: m.is_br = 0;
        endcase
        m.target = pcv + 32'(4 + off * 4);
        m.corr   = m.taken ? m.target : pcv + 32'd8;
        m.mis    = (m.taken != ptv) || (m.taken && ptv && ptg != m.target);
        return m;
    endfunction

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic drive(input logic [5:0] o, input logic [4:0] r,
                         input logic [31:0] av, bv, pcv,
                         input logic [15:0] iv, input bit ptv,
                         input logic [31:0] ptg);
        op = o; rt = r; a = av; b = bv; pc = pcv; imm = iv;
        pred_taken = ptv; pred_target = ptg;
    endtask

    // Issue one branch from idle, then walk every cycle through resolution,
    // the optional redirect hold and its release by ready or flush.
    task automatic run_one(input logic [5:0] o, input logic [4:0] r,
                           input logic [31:0] av, bv, pcv,
                           input logic [15:0] iv, input bit ptv,
                           input logic [31:0] ptg, input int hold,
                           input bit use_flush);
        mres_t m;
        int rr;
        bit ov_e, rv_e, ir_e;
        int cnt_got, cnt_exp;
        m = model(o, r, av, bv, pcv, iv, ptv, ptg);
        rr = 3 + hold;
        drive(o, r, av, bv, pcv, iv, ptv, ptg);
        in_valid = 1'b1;
        for (int c = 0; c <= rr + 1; c++) begin
            if (c == rr) begin
                if (use_flush) flush = 1'b1;
                else redirect_ready = 1'b1;
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                ov_e = m.is_br && (c == 1 + i);
                rv_e = m.is_br && m.mis && (c >= 2 + i) && (c <= rr);
                ir_e = !(m.is_br && m.mis && (c >= 1 + i) && (c <= rr));
                checks++;
                if (ov[i] !== ov_e) begin
                    errors++;
                    $display("FAIL out_valid u%0d c%0d op%0d: got %b want %b",
                             i, c, o, ov[i], ov_e);
                end
                checks++;
                if (rv[i] !== rv_e) begin
                    errors++;
                    $display("FAIL redirect_valid u%0d c%0d: got %b want %b",
                             i, c, rv[i], rv_e);
                end
                checks++;
                if (ir[i] !== ir_e) begin
                    errors++;
                    $display("FAIL in_ready u%0d c%0d: got %b want %b",
                             i, c, ir[i], ir_e);
                end
                if (ov_e) begin
                    checks++;
                    if (ot[i] !== m.taken || ol[i] !== m.link) begin
                        errors++;
                        $display("FAIL taken/link u%0d: got %b/%b want %b/%b",
                                 i, ot[i], ol[i], m.taken, m.link);
                    end
                end
                if (rv_e) begin
                    last_rpc[i] = rpc[i];
                    checks++;
                    if (rpc[i] !== m.corr) begin
                        errors++;
                        $display("FAIL redirect_pc u%0d c%0d: got %h want %h",
                                 i, c, rpc[i], m.corr);
                    end
                end
                if (c == rr + 1) begin
                    cnt_got = (i == 0) ? int'(bc0) : int'(bc1);
                    cnt_exp = (i == 0) ? exp_b : sat4(exp_b);
                    checks++;
                    if (cnt_got != cnt_exp) begin
                        errors++;
                        $display("FAIL branch_cnt u%0d: got %0d want %0d",
                                 i, cnt_got, cnt_exp);
                    end
                    cnt_got = (i == 0) ? int'(mc0) : int'(mc1);
                    cnt_exp = (i == 0) ? exp_m : sat4(exp_m);
                    checks++;
                    if (cnt_got != cnt_exp) begin
                        errors++;
                        $display("FAIL mispred_cnt u%0d: got %0d want %0d",
                                 i, cnt_got, cnt_exp);
                    end
                end
            end
            if (c == 1 && m.is_br) begin
                exp_b++;
                if (m.mis) exp_m++;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            flush = 1'b0;
            redirect_ready = 1'b0;
            drive($urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; redirect_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ov[i] !== 0 || ot[i] !== 0 || ol[i] !== 0 || rv[i] !== 0 ||
                rpc[i] !== 0 || ir[i] !== 1) begin
                errors++;
                $display("FAIL reset u%0d: got ov%b ot%b ol%b rv%b rpc%h ir%b want 0s ir1",
                         i, ov[i], ot[i], ol[i], rv[i], rpc[i], ir[i]);
            end
        end
        checks++;
        if (bc0 !== 0 || mc0 !== 0 || bc1 !== 0 || mc1 !== 0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d %0d %0d %0d want 0",
                     bc0, mc0, bc1, mc1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        run_one(6'd4, 0, 32'h5, 32'h5, 32'h400, 16'h4, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (last_rpc[i] !== 32'h414) begin
                errors++;
                $display("FAIL beq_rpc u%0d: got %h want 00000414", i, last_rpc[i]);
            end
        end
        checks++;
        if (mc0 !== 32'd1) begin
            errors++;
            $display("FAIL beq_mcnt: got %0d want 1", mc0);
        end
        run_one(6'd7, 0, 32'h80000000, 0, 32'h800, 16'h10, 0, 0, 0, 0);
        run_one(6'd7, 0, 32'h0, 0, 32'h800, 16'h10, 0, 0, 0, 0);
        run_one(6'd1, 5'd16, 32'hFFFFFFFF, 0, 32'h1000, 16'h10, 1,
                32'h1044, 0, 0);
        run_one(6'd5, 0, 32'h1, 32'h2, 32'h2000, 16'h8, 1, 32'h2000, 5, 0);
        run_one(6'd4, 0, 32'h7, 32'h7, 32'h10, 16'h8000, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (last_rpc[i] !== 32'hFFFE0014) begin
                errors++;
                $display("FAIL wrap_rpc u%0d: got %h want fffe0014", i, last_rpc[i]);
            end
        end
        run_one(6'd1, 5'd2, 32'hFFFFFFFF, 0, 32'h40, 16'h4, 1, 0, 0, 0);
    endtask

    task automatic test_flush();
        run_one(6'd4, 0, 32'h9, 32'h9, 32'h300, 16'h2, 0, 0, 1, 1);
        drive(6'd4, 0, 32'h1, 32'h1, 32'h500, 16'h1, 0, 0);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ov[i] !== 1'b0 || rv[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_kill u%0d c%0d: got ov%b rv%b want 0",
                             i, c, ov[i], rv[i]);
                end
            end
            @(posedge clk);
            #1;
            flush = 1'b0;
        end
        checks++;
        if (bc0 !== 32'(exp_b) || mc0 !== 32'(exp_m)) begin
            errors++;
            $display("FAIL flush_cnt: got %0d/%0d want %0d/%0d",
                     bc0, mc0, exp_b, exp_m);
        end
    endtask

    task automatic test_midstream_reset();
        drive(6'd5, 0, 32'h1, 32'h2, 32'h600, 16'h3, 0, 0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rv[i] !== 1'b1) begin
                errors++;
                $display("FAIL pre_reset_rv u%0d: got %b want 1", i, rv[i]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_b = 0;
        exp_m = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ov[i] !== 0 || rv[i] !== 0 || rpc[i] !== 0 || ir[i] !== 1) begin
                errors++;
                $display("FAIL mid_reset u%0d: got ov%b rv%b rpc%h ir%b want 0 0 0 1",
                         i, ov[i], rv[i], rpc[i], ir[i]);
            end
        end
        checks++;
        if (bc0 !== 0 || mc0 !== 0 || bc1 !== 0 || mc1 !== 0) begin
            errors++;
            $display("FAIL mid_reset_cnt: got %0d %0d %0d %0d want 0",
                     bc0, mc0, bc1, mc1);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_a();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl [8] = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd1, 6'd35, 6'd0};
        return tbl[$urandom % 8];
    endfunction

    function automatic logic [4:0] pick_rt();
        logic [4:0] tbl [5] = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd3};
        return tbl[$urandom % 5];
    endfunction

    task automatic test_random_mispredict();
        mres_t m;
        logic [5:0] o;
        logic [4:0] r;
        logic [31:0] av, bv, pcv, ptg;
        logic [15:0] iv;
        bit ptv;
        for (int k = 0; k < 30; k++) begin
            o = pick_op(); r = pick_rt(); av = pick_a();
            bv = ($urandom % 2) ? av : $urandom;
            pcv = {$urandom, 2'b00}; iv = $urandom;
            m = model(o, r, av, bv, pcv, iv, 0, 0);
            ptv = $urandom % 2;
            ptg = ($urandom % 2) ? m.target : $urandom;
            run_one(o, r, av, bv, pcv, iv, ptv, ptg, $urandom % 3,
                    ($urandom % 4) == 0);
        end
    endtask

    task automatic test_back_to_back();
        mres_t m;
        ent_t e;
        bit ev;
        bit is_br;
        logic [5:0] o;
        logic [4:0] r;
        logic [31:0] av, bv, pcv;
        logic [15:0] iv;
        for (int c = 0; c < 43; c++) begin
            is_br = 0;
            if (c < 40) begin
                o = pick_op(); r = pick_rt(); av = pick_a();
                bv = ($urandom % 2) ? av : $urandom;
                pcv = {$urandom, 2'b00}; iv = $urandom;
                m = model(o, r, av, bv, pcv, iv, 0, 0);
                drive(o, r, av, bv, pcv, iv, m.taken,
                      m.taken ? m.target : $urandom);
                in_valid = 1'b1;
                is_br = m.is_br;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                ev = (i == 0) ? (q0.size() > 0 && q0[0].due == c)
                              : (q1.size() > 0 && q1[0].due == c);
                checks++;
                if (ov[i] !== ev || ir[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_valid u%0d c%0d: got ov%b ir%b want ov%b ir1",
                             i, c, ov[i], ir[i], ev);
                end
                if (ev) begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    if (i == 0) exp_b++;
                    checks++;
                    if (ot[i] !== e.taken || ol[i] !== e.link) begin
                        errors++;
                        $display("FAIL b2b_result u%0d c%0d: got %b/%b want %b/%b",
                                 i, c, ot[i], ol[i], e.taken, e.link);
                    end
                end
            end
            @(posedge clk);
            if (is_br) begin
                q0.push_back('{c + 1, m.taken, m.link});
                q1.push_back('{c + 2, m.taken, m.link});
            end
            #1;
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d/%0d left want 0",
                     q0.size(), q1.size());
        end
        checks++;
        if (bc0 !== 32'(exp_b) || int'(bc1) != sat4(exp_b) ||
            mc0 !== 32'(exp_m) || int'(mc1) != sat4(exp_m)) begin
            errors++;
            $display("FAIL b2b_cnt: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                     bc0, bc1, mc0, mc1, exp_b, sat4(exp_b), exp_m, sat4(exp_m));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_midstream_reset();
        test_random_mispredict();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
